range_prep_unit: RTL and testbench
==================================

// Module: range_prep_unit
// PURPOSE
//  Parametrised argument-preparation stage in front of the iterative CORDIC/sqrt cores.
//  - Trig (sin/cos): folds the sign into a quadrant code.
//  - Sqrt: splits the operand into a mantissa in [0.5,2) and a signed half-exponent.
//  - Exact FP pass-through for the remaining modes.
//  - Unlike the fixed-64-bit correction stage, it is width-generic, uses a valid/ready
//    handshake on both sides, holds its result under backpressure and reports class flags.
// PARAMETERS
//  EXP_W   11  exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   52  fraction field width; operand width W = 1+EXP_W+MAN_W
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operand/mode valid
//  in_ready    out  1      block can accept an operand
//  mode        in   3      4/5 = sin/cos, 6 = sqrt, 7 = pass, others = unsupported
//  operand     in   W      IEEE-style {sign, exp, frac}
//  out_valid   out  1      result/exponent/quadrant/flags valid
//  out_ready   in   1      consumer accepts result
//  result      out  W      corrected operand
//  exponent    out  EXP_W  two's-complement half-exponent (sqrt only)
//  quadrant    out  3      quadrant code (trig only)
//  flags       out  4      [0] exp==0  [1] sign set  [2] exp all-ones  [3] unsupported mode
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - All outputs 0; in_ready 0 while held in reset; FSM enters S_IDLE.
//  - Reset mid-operation discards the pending operand; no output pulse follows.
//  FSM, one transaction at a time
//  - S_IDLE: in_ready=1. in_valid at an edge captures mode/operand -> S_CALC.
//  - S_CALC: in_ready=0. Registers result/exponent/quadrant/flags and sets out_valid -> S_HOLD.
//  - S_HOLD: out_valid=1; outputs stable until out_ready=1 at an edge.
//    That edge clears out_valid -> S_IDLE.
//  - Latency: operand accepted at edge N -> out_valid high after edge N+1.
//  - Minimum initiation interval: 3 cycles.
//  - in_valid outside S_IDLE is ignored; no data is captured.
//  Mode 4/5 (trig)
//  - result = operand with sign bit cleared.
//  - quadrant = 4 if sign=1, else 1.
//  Mode 6 (sqrt), with E = exp field and e = E-BIAS
//  - Sign and fraction are copied unchanged.
//  - e even: result exp field = BIAS, exponent = e/2.
//  - e odd: result exp field = BIAS-1, exponent = (e+1)/2.
//  - Arithmetic is done at EXP_W+1 bits signed; the result is exact, no saturation needed.
//  - E==0 or E all-ones: result = operand, exponent = 0, flags[0] or flags[2] set.
//  Mode 7: result = operand.
//  Other modes: result = operand, flags[3] = 1.
//  Register retention
//  - quadrant is updated only for modes 4/5; exponent only for mode 6.
//  - Otherwise both keep their previous values.
//  - flags[0..2] are computed from the operand for every mode.
//  - result and flags are rewritten on every transaction.
// TESTING
//  - mode=6, op=0x4030000000000000 (16.0) -> result 0x3FF0000000000000, exponent 2, flags 0.
//  - mode=6, op=0x4020000000000000 (8.0) -> result 0x3FE0000000000000, exponent 2.
//    Then op=0x3FD0000000000000 (0.25) -> result 0x3FF0000000000000, exponent 0x7FF (-1).
//  - mode=4, op=0xBFF0000000000000 -> result 0x3FF0000000000000, quadrant 4, flags[1]=1.
//    Then mode=7 -> quadrant stays 4.
//  - Backpressure: out_ready low 5 cycles -> out_valid and outputs stable, in_ready 0, extra
//    in_valid ignored. out_ready=1 -> out_valid drops next edge, in_ready back to 1.
//  - mode=6 with op=0 and with op=0x7FF0000000000000 -> passthrough, exponent 0,
//    flags 0x1 and 0x4 respectively. mode=2 -> flags[3]=1.
//  - Assert rst_n=0 in S_CALC -> outputs 0 immediately. After release, first transaction
//    completes with 2-edge latency and no stale out_valid.

Source files
------------

// File: rtl/range_prep_unit.sv
`default_nettype none
// ============================================================================
// Module   : range_prep_unit
// Brief    : Width-generic argument preparation ahead of the CORDIC/sqrt cores:
//            trig quadrant folding, sqrt mantissa/half-exponent split, pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module range_prep_unit #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             mode,
    input  logic [EXP_W+MAN_W:0]   operand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [EXP_W-1:0]       exponent,
    output logic [2:0]             quadrant,
    output logic [3:0]             flags
);

    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] c_bias     = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] c_bias_m1  = {1'b0, {(EXP_W-2){1'b1}}, 1'b0};
    localparam logic [2:0]       c_mode_sin  = 3'd4;
    localparam logic [2:0]       c_mode_cos  = 3'd5;
    localparam logic [2:0]       c_mode_sqrt = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [W-1:0]     r_operand;
    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic [EXP_W-1:0] r_exponent;
    logic [2:0]       r_quadrant;
    logic [3:0]       r_flags;

    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic             w_exp_zero;
    logic             w_exp_ones;
    logic             w_special;
    logic             w_is_trig;
    logic             w_is_sqrt;
    logic [EXP_W:0]   w_e_p1;
    logic             w_e_odd;
    logic [EXP_W-1:0] w_half_exp;
    logic [W-1:0]     w_result;
    logic [3:0]       w_flags;

    assign w_sign     = r_operand[W-1];
    assign w_exp      = r_operand[W-2 -: EXP_W];
    assign w_exp_zero = (w_exp == '0);
    assign w_exp_ones = (w_exp == '1);
    assign w_special  = w_exp_zero | w_exp_ones;
    assign w_is_trig  = (r_mode == c_mode_sin) || (r_mode == c_mode_cos);
    assign w_is_sqrt  = (r_mode == c_mode_sqrt);

    // w_e_p1 = e+1 in two's complement. floor((e+1)/2) is e/2 for even e and
    // (e+1)/2 for odd e, so the half-exponent is just its upper bits.
    assign w_e_p1     = {1'b0, w_exp} - {1'b0, c_bias_m1};
    assign w_e_odd    = ~w_e_p1[0];
    assign w_half_exp = w_e_p1[EXP_W:1];

    assign w_flags    = {~r_mode[2], w_exp_ones, w_sign, w_exp_zero};

    always_comb begin
        w_result = r_operand;
        if (w_is_trig) begin
            w_result[W-1] = 1'b0;
        end else if (w_is_sqrt && !w_special) begin
            w_result[W-2 -: EXP_W] = w_e_odd ? c_bias_m1 : c_bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_operand   <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_exponent  <= '0;
            r_quadrant  <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode    <= mode;
                        r_operand <= operand;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_result    <= w_result;
                    r_flags     <= w_flags;
                    r_out_valid <= 1'b1;
                    if (w_is_trig) begin
                        r_quadrant <= w_sign ? 3'd4 : 3'd1;
                    end
                    if (w_is_sqrt) begin
                        r_exponent <= w_special ? '0 : w_half_exp;
                    end
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational with rst_n so the block never advertises readiness in reset.
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign exponent  = r_exponent;
    assign quadrant  = r_quadrant;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_range_prep_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_prep_unit
// Brief    : Scoreboard bench for range_prep_unit with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_prep_unit;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int BIAS  = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  mode = 3'd0;
    logic [63:0] operand = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic [10:0] exponent;
    logic [2:0]  quadrant;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [10:0] ex;
        logic [2:0]  q;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [10:0] m_ex = 11'd0;
    logic [2:0]  m_q  = 3'd0;

    range_prep_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .exponent(exponent), .quadrant(quadrant), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: plain integer arithmetic on the unbiased exponent.
    task automatic model_push(input logic [2:0] m, input logic [63:0] op);
        exp_t x;
        int   ef;
        int   e;
        int   half;
        ef   = int'(op[62:52]);
        x.res = op;
        x.fl  = {(m < 3'd4), (ef == 2047), op[63], (ef == 0)};
        if (m == 3'd4 || m == 3'd5) begin
            x.res[63] = 1'b0;
            m_q = op[63] ? 3'd4 : 3'd1;
        end else if (m == 3'd6) begin
            if (ef == 0 || ef == 2047) begin
                m_ex = 11'd0;
            end else begin
                e = ef - BIAS;
                if (e % 2 == 0) begin
                    half = e / 2;
                    x.res[62:52] = 11'(BIAS);
                end else begin
                    half = (e + 1) / 2;
                    x.res[62:52] = 11'(BIAS - 1);
                end
                m_ex = 11'(half);
            end
        end
        x.ex = m_ex;
        x.q  = m_q;
        sb.push_back(x);
    endtask

    task automatic send(input logic [2:0] m, input logic [63:0] op);
        int n;
        in_valid = 1'b1;
        mode     = m;
        operand  = op;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            fail_now("accept");
            in_valid = 1'b0;
        end else begin
            model_push(m, op);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) fail_now("out_valid");
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result",   result,        mon_e.res);
                chk("sb_exponent", 64'(exponent), 64'(mon_e.ex));
                chk("sb_quadrant", 64'(quadrant), 64'(mon_e.q));
                chk("sb_flags",    64'(flags),    64'(mon_e.fl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap_res;
        logic [3:0]  snap_fl;
        logic [63:0] op;
        int          n;

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_result",    result,         64'd0);
        chk("rst_exponent",  64'(exponent),  64'd0);
        chk("rst_quadrant",  64'(quadrant),  64'd0);
        chk("rst_flags",     64'(flags),     64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        send(3'd6, 64'h4030000000000000);
        wait_out();
        chk("sqrt16_result",   result,         64'h3FF0000000000000);
        chk("sqrt16_exponent", 64'(exponent),  64'd2);
        chk("sqrt16_flags",    64'(flags),     64'd0);

        send(3'd6, 64'h4020000000000000);
        wait_out();
        chk("sqrt8_result",   result,        64'h3FE0000000000000);
        chk("sqrt8_exponent", 64'(exponent), 64'd2);

        send(3'd6, 64'h3FD0000000000000);
        wait_out();
        chk("sqrtq_result",   result,        64'h3FF0000000000000);
        chk("sqrtq_exponent", 64'(exponent), 64'h7FF);

        send(3'd4, 64'hBFF0000000000000);
        wait_out();
        chk("sin_result",   result,        64'h3FF0000000000000);
        chk("sin_quadrant", 64'(quadrant), 64'd4);
        chk("sin_flags",    64'(flags),    64'h2);

        send(3'd7, 64'h4000000000000000);
        wait_out();
        chk("pass_result",   result,        64'h4000000000000000);
        chk("pass_quadrant", 64'(quadrant), 64'd4);
        chk("pass_exponent", 64'(exponent), 64'h7FF);

        send(3'd6, 64'h0000000000000000);
        wait_out();
        chk("sqrt0_result",   result,        64'h0);
        chk("sqrt0_exponent", 64'(exponent), 64'd0);
        chk("sqrt0_flags",    64'(flags),    64'h1);

        send(3'd6, 64'h7FF0000000000000);
        wait_out();
        chk("sqrtinf_result",   result,        64'h7FF0000000000000);
        chk("sqrtinf_exponent", 64'(exponent), 64'd0);
        chk("sqrtinf_flags",    64'(flags),    64'h4);

        send(3'd2, 64'h3FF0000000000000);
        wait_out();
        chk("unsup_result", result,     64'h3FF0000000000000);
        chk("unsup_flags",  64'(flags), 64'h8);

        // Backpressure: outputs must hold and extra operands be ignored.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(3'd5, 64'hC008000000000000);
        wait_out();
        snap_res = result;
        snap_fl  = flags;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            mode     = 3'd6;
            operand  = 64'h4050000000000000;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_result",    result,         snap_res);
            chk("bp_flags",     64'(flags),     64'(snap_fl));
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready),  64'd1);

        // Reset while in S_CALC discards the pending operand.
        send(3'd6, 64'h4030000000000000);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd0);
        chk("midrst_result",    result,         64'd0);
        chk("midrst_exponent",  64'(exponent),  64'd0);
        chk("midrst_quadrant",  64'(quadrant),  64'd0);
        chk("midrst_flags",     64'(flags),     64'd0);
        sb.delete();
        m_q  = 3'd0;
        m_ex = 11'd0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_pulse", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_no_stale", 64'(out_valid), 64'd0);
        send(3'd6, 64'h4020000000000000);
        chk("lat_calc_valid", 64'(out_valid), 64'd0);
        chk("lat_calc_ready", 64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_result",    result,         64'h3FE0000000000000);

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 300; t++) begin
            op = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       op[62:52] = 11'h000;
                1:       op[62:52] = 11'h7FF;
                2:       op[62:52] = 11'(BIAS + int'($urandom_range(0, 6)) - 3);
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                send(3'($urandom_range(0, 3)), op);
            else
                send(3'($urandom_range(4, 7)), op);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        rdy_mode = 0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail_now("drain");
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
